// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/response and adder-slice signal bundle for serial_add_ctrl
interface serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output in_valid, a, b, sub, out_ready, add_s, add_cout,
        input  in_ready, add_a, add_b, add_cin, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready, add_s, add_cout,
        output in_ready, add_a, add_b, add_cin, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - nibble-serial add/subtract controller driving a shared external 4-bit adder slice
module serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  io
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [3:0]      a_nib, b_nib;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        a_nib = 4'd0;
        b_nib = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    // Subtract is A + ~B + 1: invert B once here, seed the carry with 1.
                    a_d     = io.a;
                    b_d     = io.sub ? ~io.b : io.b;
                    carry_d = io.sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[4*i +: 4] = io.add_s;
                    end
                end
                carry_d = io.add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = io.add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (io.add_s[3] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.add_a     = (state_q == RUN) ? a_nib : 4'd0;
    assign io.add_b     = (state_q == RUN) ? b_nib : 4'd0;
    assign io.add_cin   = (state_q == RUN) && carry_q;
    assign io.sum       = sum_q;
    assign io.carry_out = cout_q;
    assign io.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl with a behavioural 4-bit adder slice
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_cnt = 0;
    int   acc_q[$];
    logic cin_log [0:19];

    serial_add_ctrl_if #(.NIBBLES(4)) bus ();

    serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    always_comb begin
        {bus.add_cout, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst_n && bus.in_valid && bus.in_ready) acc_q.push_back(cyc_cnt);
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic op_sub, input logic [15:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf, input int hold);
        int         cyc;
        logic [3:0] exp_b0;
        exp_b0 = op_sub ? ~op_b[3:0] : op_b[3:0];
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a = op_a; bus.b = op_b; bus.sub = op_sub; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_add_a0"}, 32'(bus.add_a), 32'(op_a[3:0]));
        chk({tag, "_add_b0"}, 32'(bus.add_b), 32'(exp_b0));
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            cin_log[cyc] = bus.add_cin;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd4);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_carry_out"}, 32'(bus.carry_out), 32'(exp_cout));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = h[0];
            bus.a = 16'hAAAA;
            @(negedge clk);
            chk({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "_hold_sum"}, 32'(bus.sum), 32'(exp_sum));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_idle_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_idle_carry"}, 32'(bus.carry_out), 32'(exp_cout));
    endtask

    initial begin
        int done_cnt;
        int guard;
        int ov_seen;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_add_a", 32'(bus.add_a), 32'd0);
        chk("rst_add_b", 32'(bus.add_b), 32'd0);
        chk("rst_add_cin", 32'(bus.add_cin), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_carry_out", 32'(bus.carry_out), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;

        do_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);

        do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        chk("wrap_cin0", 32'(cin_log[0]), 32'd0);
        chk("wrap_cin1", 32'(cin_log[1]), 32'd1);
        chk("wrap_cin2", 32'(cin_log[2]), 32'd1);
        chk("wrap_cin3", 32'(cin_log[3]), 32'd1);

        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        chk("sub_ovf_cin0", 32'(cin_log[0]), 32'd1);
        do_op("sub_neg", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op("sub_zero", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);

        do_op("backpressure", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 10);

        acc_q.delete();
        done_cnt = 0;
        guard = 0;
        @(negedge clk);
        bus.a = 16'h0101; bus.b = 16'h0202; bus.sub = 1'b0; bus.in_valid = 1'b1;
        while (done_cnt < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (bus.out_valid && !bus.out_ready) begin
                chk("b2b_sum", 32'(bus.sum), 32'h0303);
                bus.out_ready = 1'b1;
                done_cnt++;
                if (done_cnt == 3) bus.in_valid = 1'b0;
            end else begin
                bus.out_ready = 1'b0;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("b2b_done_cnt", 32'(done_cnt), 32'd3);
        chk("b2b_accepts", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) begin
            chk("b2b_period_1", 32'(acc_q[1] - acc_q[0]), 32'd6);
            chk("b2b_period_2", 32'(acc_q[2] - acc_q[1]), 32'd6);
        end

        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_add_a_idx2", 32'(bus.add_a), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrun_rst_sum", 32'(bus.sum), 32'd0);
        chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrun_rst_add_cin", 32'(bus.add_cin), 32'd0);
        rst_n = 1'b1;
        ov_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) ov_seen++;
        end
        chk("midrun_no_out_valid", 32'(ov_seen), 32'd0);
        do_op("after_rst", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
